spi_bus_arb: RTL and testbench

Round-robin arbiter that shares one physical SPI bus (SCLK, COPI, CIPO, one chip select) between several SPI host controllers in the system clock domain. It sits between the SPI host instances and the pin multiplexer. It grants the bus to one requester per transaction, enforces a chip-select-high gap between owners, and revokes ownership from a requester that holds the bus too long.

---
 rtl/spi_bus_arb.sv | 175 +++++++++++++++++
 tb/tb_spi_bus_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arb.sv
// spi_bus_arb: hands one shared SPI bus to one of NumReq host controllers at a time,
// round-robin, with a forced chip-select-high gap between owners and hold-time revocation.
module spi_bus_arb #(
    parameter int NumReq        = 2,
    parameter int GapCycles     = 2,
    parameter int MaxHoldCycles = 65535
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    input  logic [NumReq-1:0] sck_i,
    input  logic [NumReq-1:0] copi_i,
    input  logic [NumReq-1:0] cs_ni,
    output logic [NumReq-1:0] cipo_o,
    output logic              spi_sck_o,
    output logic              spi_copi_o,
    output logic              spi_cs_no,
    input  logic              spi_cipo_i,
    output logic              busy_o,
    output logic              timeout_o
);
    localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int HW = (MaxHoldCycles > 0) ? $clog2(MaxHoldCycles + 1) : 1;
    localparam int GW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [HW-1:0] HoldLimit = HW'(MaxHoldCycles - 1);
    localparam logic [HW-1:0] HoldSat   = {HW{1'b1}};
    localparam logic [GW-1:0] GapLoad   = GW'(GapCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [NumReq-1:0] blocked_q, blocked_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;

    logic [NumReq-1:0] eligible_s;
    logic              pick_found_s;
    logic [IW-1:0]     pick_idx_s;
    logic [IW:0]       cand_s;

    // Round-robin search: scan from farthest to nearest after last_q so the nearest eligible wins.
    always_comb begin
        eligible_s   = req_i & ~blocked_q;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = NumReq; k >= 1; k--) begin
            cand_s = {1'b0, last_q} + (IW+1)'(k);
            cand_s = (cand_s >= (IW+1)'(NumReq)) ? (cand_s - (IW+1)'(NumReq)) : cand_s;
            if (eligible_s[cand_s[IW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[IW-1:0];
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Next-state logic; the final gap cycle arbitrates so CS is high for exactly GapCycles.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        blocked_d = blocked_q & req_i;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d             = ST_GRANT;
                    owner_d             = pick_idx_s;
                    last_d              = pick_idx_s;
                    gnt_d               = '0;
                    gnt_d[pick_idx_s]   = 1'b1;
                    hold_d              = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                hold_d = (hold_q == HoldSat) ? hold_q : (hold_q + HW'(1));
                if (!req_i[owner_q]) begin
                    gnt_d   = '0;
                    gap_d   = GapLoad;
                    state_d = ST_GAP;
                end else if ((MaxHoldCycles != 0) && (hold_q == HoldLimit)) begin
                    gnt_d              = '0;
                    gap_d              = GapLoad;
                    state_d            = ST_GAP;
                    blocked_d[owner_q] = 1'b1;
                    timeout_d          = 1'b1;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (pick_found_s) begin
                    state_d             = ST_GRANT;
                    owner_d             = pick_idx_s;
                    last_d              = pick_idx_s;
                    gnt_d               = '0;
                    gnt_d[pick_idx_s]   = 1'b1;
                    hold_d              = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            last_q    <= IW'(NumReq - 1);
            gnt_q     <= '0;
            blocked_q <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            blocked_q <= blocked_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Shared bus follows the registered owner with no added delay; idle levels otherwise.
    always_comb begin
        spi_sck_o  = 1'b0;
        spi_copi_o = 1'b0;
        spi_cs_no  = 1'b1;
        cipo_o     = '0;
        if (state_q == ST_GRANT) begin
            spi_sck_o       = sck_i[owner_q];
            spi_copi_o      = copi_i[owner_q];
            spi_cs_no       = cs_ni[owner_q];
            cipo_o[owner_q] = spi_cipo_i;
        end else begin
            spi_cs_no = 1'b1;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: directed checks of two arbiter configurations against a
// cycle-level behavioural model plus hand-computed literal expectations.
module tb_spi_bus_arb;
    logic clk = 1'b0;
    logic rst_ni = 1'b1;

    // Instance A: 3 requesters, gap 2, default hold limit.
    logic [2:0] req_a = 3'b000, sck_a = 3'b000, copi_a = 3'b000, cs_a = 3'b111;
    logic [2:0] gnt_a, cipo_a;
    logic sck_oa, copi_oa, cs_oa, busy_a, to_a;
    logic cipo_ia = 1'b0;

    // Instance B: 2 requesters, gap 2, hold limit 8.
    logic [1:0] req_b = 2'b00, sck_b = 2'b00, copi_b = 2'b00, cs_b = 2'b11;
    logic [1:0] gnt_b, cipo_b;
    logic sck_ob, copi_ob, cs_ob, busy_b, to_b;
    logic cipo_ib = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_bus_arb #(.NumReq(3), .GapCycles(2), .MaxHoldCycles(65535)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_a), .gnt_o(gnt_a),
        .sck_i(sck_a), .copi_i(copi_a), .cs_ni(cs_a), .cipo_o(cipo_a),
        .spi_sck_o(sck_oa), .spi_copi_o(copi_oa), .spi_cs_no(cs_oa),
        .spi_cipo_i(cipo_ia), .busy_o(busy_a), .timeout_o(to_a)
    );

    spi_bus_arb #(.NumReq(2), .GapCycles(2), .MaxHoldCycles(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_b), .gnt_o(gnt_b),
        .sck_i(sck_b), .copi_i(copi_b), .cs_ni(cs_b), .cipo_o(cipo_b),
        .spi_sck_o(sck_ob), .spi_copi_o(copi_ob), .spi_cs_no(cs_ob),
        .spi_cipo_i(cipo_ib), .busy_o(busy_b), .timeout_o(to_b)
    );

    // Behavioural model: owner (-1 = none), gap cycles still to show, grant cycles held.
    int       m_owner[2];
    int       m_last[2];
    int       m_held[2];
    int       m_gapleft[2];
    bit       m_to[2];
    bit [3:0] m_blk[2];

    function automatic int np(int n);
        return (n == 0) ? 3 : 2;
    endfunction

    function automatic int maxh(int n);
        return (n == 0) ? 65535 : 8;
    endfunction

    localparam int GAP = 2;

    task automatic model_reset(int n);
        m_owner[n]   = -1;
        m_last[n]    = np(n) - 1;
        m_held[n]    = 0;
        m_gapleft[n] = 0;
        m_to[n]      = 1'b0;
        m_blk[n]     = 4'b0000;
    endtask

    task automatic model_step(int n, bit [3:0] req);
        bit [3:0] old_blk = m_blk[n];
        m_blk[n] = old_blk & req;
        m_to[n]  = 1'b0;
        if (m_owner[n] >= 0) begin
            m_held[n]++;
            if (!req[m_owner[n]]) begin
                m_owner[n]   = -1;
                m_gapleft[n] = GAP;
            end else if (maxh(n) != 0 && m_held[n] == maxh(n)) begin
                m_blk[n][m_owner[n]] = 1'b1;
                m_to[n]      = 1'b1;
                m_owner[n]   = -1;
                m_gapleft[n] = GAP;
            end
        end else if (m_gapleft[n] > 1) begin
            m_gapleft[n]--;
        end else begin
            m_gapleft[n] = 0;
            for (int k = 1; k <= np(n); k++) begin
                int c = (m_last[n] + k) % np(n);
                if (req[c] && !old_blk[c]) begin
                    m_owner[n] = c;
                    m_last[n]  = c;
                    m_held[n]  = 0;
                    break;
                end
            end
        end
    endtask

    function automatic logic [12:0] exp_vec(int n, logic [3:0] sck, logic [3:0] copi,
                                            logic [3:0] cs, logic cipo_in);
        logic [3:0] g = 4'b0000;
        logic [3:0] c = 4'b0000;
        logic s = 1'b0;
        logic d = 1'b0;
        logic x = 1'b1;
        logic b;
        int o = m_owner[n];
        if (o >= 0) begin
            g[o] = 1'b1;
            c[o] = cipo_in;
            s    = sck[o];
            d    = copi[o];
            x    = cs[o];
        end
        b = (o >= 0) || (m_gapleft[n] > 0);
        return {g, c, s, d, x, b, m_to[n]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int owner_of(logic [2:0] g);
        return g[0] ? 0 : (g[1] ? 1 : (g[2] ? 2 : -1));
    endfunction

    // Model advances on every clock edge and resets asynchronously with the DUTs.
    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, {1'b0, req_a});
                model_step(1, {2'b00, req_b});
            end
        end
    end

    // Every falling edge: compare all outputs of both instances with the model.
    initial begin
        #2;
        forever begin
            @(negedge clk);
            chk("model_a", {19'd0, 1'b0, gnt_a, 1'b0, cipo_a, sck_oa, copi_oa, cs_oa, busy_a, to_a},
                {19'd0, exp_vec(0, {1'b0, sck_a}, {1'b0, copi_a}, {1'b0, cs_a}, cipo_ia)});
            chk("model_b", {19'd0, 2'b00, gnt_b, 2'b00, cipo_b, sck_ob, copi_ob, cs_ob, busy_b, to_b},
                {19'd0, exp_vec(1, {2'b00, sck_b}, {2'b00, copi_b}, {2'b00, cs_b}, cipo_ib)});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus with literal expectations.
    initial begin
        int exp_order[4] = '{0, 1, 2, 0};
        int order[4];
        int w, gap, own;

        req_b = 2'b11;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_cs_b", cs_ob, 1);
        chk("rst_to_b", to_b, 0);
        tick();
        tick();
        chk("rst_hold_gnt_b", gnt_b, 0);
        rst_ni = 1'b1;
        tick();
        chk("first_gnt_b", gnt_b, 2'b01);
        chk("first_busy_b", busy_b, 1);

        // Hand the bus to requester 1 and check mux routing.
        req_b = 2'b10;
        tick();
        chk("handover_gap1_gnt", gnt_b, 0);
        chk("handover_gap1_cs", cs_ob, 1);
        tick();
        chk("handover_gap2_gnt", gnt_b, 0);
        chk("handover_gap2_cs", cs_ob, 1);
        tick();
        chk("handover_gnt_b", gnt_b, 2'b10);
        cs_b = 2'b00;
        #1 chk("mux_cs_low", cs_ob, 0);
        sck_b = 2'b10; copi_b = 2'b10; cipo_ib = 1'b1;
        #1 chk("mux_sck_hi", sck_ob, 1);
        chk("mux_copi_hi", copi_ob, 1);
        chk("mux_cipo", cipo_b, 2'b10);
        tick();
        sck_b = 2'b01; copi_b = 2'b01;
        #1 chk("mux_sck_lo", sck_ob, 0);
        chk("mux_copi_lo", copi_ob, 0);
        cs_b = 2'b10;
        #1 chk("mux_cs_owner_only", cs_ob, 1);
        tick();
        cs_b = 2'b11; sck_b = 2'b00; copi_b = 2'b00; cipo_ib = 1'b0;
        req_b = 2'b00;
        tick();
        tick();
        tick();

        // Timeout: requester 0 holds past the limit of 8 grant cycles.
        req_b = 2'b01;
        tick();
        chk("to_gnt_c1", gnt_b, 2'b01);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_gnt_held", gnt_b, 2'b01);
            chk("to_no_pulse_early", to_b, 0);
        end
        tick();
        chk("to_revoked_gnt", gnt_b, 0);
        chk("to_pulse", to_b, 1);
        tick();
        chk("to_pulse_one_cycle", to_b, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("to_blocked_no_regrant", gnt_b, 0);
        end
        req_b = 2'b00;
        tick();
        req_b = 2'b01;
        tick();
        chk("to_regrant_after_drop", gnt_b, 2'b01);

        // Release in the 8th grant cycle wins over the timeout.
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("coll_no_pulse", to_b, 0);
        end
        req_b = 2'b00;
        tick();
        chk("coll_gnt_dropped", gnt_b, 0);
        chk("coll_no_timeout", to_b, 0);
        req_b = 2'b01;
        tick();
        tick();
        chk("coll_regrant", gnt_b, 2'b01);
        req_b = 2'b00;
        tick();

        // Round robin on the 3-requester instance.
        req_a = 3'b111;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            gap = 0;
            while (gnt_a == 3'b000 && w < 20) begin
                if (cs_oa) gap++;
                tick();
                w++;
            end
            chk("rr_grant_seen", (gnt_a != 3'b000), 1);
            own = owner_of(gnt_a);
            order[g] = own;
            chk("rr_order", order[g], exp_order[g]);
            if (g > 0) chk("rr_gap_cycles", gap, 2);
            if (own >= 0) begin
                cs_a[own] = 1'b0;
                repeat (9) tick();
                chk("rr_cs_routed", cs_oa, 0);
                cs_a[own] = 1'b1;
                tick();
                req_a[own] = 1'b0;
                tick();
                chk("rr_release_gnt", gnt_a, 0);
                req_a[own] = 1'b1;
            end
        end

        // Asynchronous reset mid-grant.
        w = 0;
        while (gnt_a == 3'b000 && w < 20) begin
            tick();
            w++;
        end
        chk("ar_grant_seen", gnt_a, 3'b010);
        cs_a[1] = 1'b0;
        #1 chk("ar_cs_low", cs_oa, 0);
        tick();
        rst_ni = 1'b0;
        #1 chk("ar_cs_forced", cs_oa, 1);
        chk("ar_gnt_dropped", gnt_a, 0);
        cs_a = 3'b111;
        #5 rst_ni = 1'b1;
        tick();
        chk("ar_restart_req0", gnt_a, 3'b001);
        req_a = 3'b000;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
